el2_dccm_port_arb: RTL
======================

# el2_dccm_port_arb

Arbiter and sequencer for the single read/write port of the DCCM. It shares the port between the LSU (no buffering, default priority) and the DMA slave (one-entry request buffer, starvation-protected). It drives the DCCM low-lane control and data signals, and routes the 1-cycle-latency read data back to the requester that issued the read. It sits between the LSU/DMA front ends and the DCCM memory wrapper.

## Interface
Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DCCM_FDATA_WIDTH, 39, DCCM data width including ECC (32+7).
- DMA_STARVE_MAX, 7, number of consecutive blocked cycles after which DMA wins priority (1..15).
- DMA_TAG_W, 3, width of the DMA request tag.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- lsu_req_valid  in  1  LSU access request.
- lsu_req_wr  in  1  1 = write, 0 = read.
- lsu_req_addr  in  DCCM_BITS  LSU address.
- lsu_req_wdata  in  DCCM_FDATA_WIDTH  LSU write data.
- lsu_req_ready  out  1  LSU granted this cycle (combinational).
- dma_req_valid  in  1  DMA access request.
- dma_req_wr  in  1  1 = write.
- dma_req_addr  in  DCCM_BITS  DMA address.
- dma_req_wdata  in  DCCM_FDATA_WIDTH  DMA write data.
- dma_req_tag  in  DMA_TAG_W  DMA read tag.
- dma_req_ready  out  1  DMA buffer can accept.
- dccm_wren  out  1  DCCM write enable.
- dccm_rden  out  1  DCCM read enable.
- dccm_wr_addr_lo  out  DCCM_BITS  write address.
- dccm_rd_addr_lo  out  DCCM_BITS  read address.
- dccm_wr_data_lo  out  DCCM_FDATA_WIDTH  write data.
- dccm_rd_data_lo  in  DCCM_FDATA_WIDTH  read data, valid the cycle after dccm_rden.
- lsu_rd_valid  out  1  LSU read data valid.
- lsu_rd_data  out  DCCM_FDATA_WIDTH  LSU read data.
- dma_rd_valid  out  1  DMA read data valid.
- dma_rd_tag  out  DMA_TAG_W  tag of the returning DMA read.
- dma_rd_data  out  DCCM_FDATA_WIDTH  DMA read data.
- dma_starve  out  1  starvation override active this cycle.

## Operation
- **DMA buffer.** One entry: valid, wr, addr, wdata, tag.
  - Loads on dma_req_valid & dma_req_ready.
  - Clears on DMA grant unless reloaded in the same cycle.
  - dma_req_ready = !rst & (!buf_valid | dma_grant). This allows back-to-back DMA acceptance.
- **Grant.** At most one grant per cycle.
  - dma_starve = buf_valid & (starve_cnt == DMA_STARVE_MAX).
  - dma_grant = buf_valid & (!lsu_req_valid | dma_starve).
  - lsu_grant = lsu_req_valid & !dma_grant.
  - lsu_req_ready = lsu_grant. LSU requests are not buffered; LSU holds its request until ready.
- **Starvation counter.** Width ceil(log2(DMA_STARVE_MAX+1)).
  - Clears on reset, on dma_grant, or when !buf_valid.
  - Increments when buf_valid & !dma_grant.
  - Saturates at DMA_STARVE_MAX.
- **Port drive.** Granted request, combinational.
  - dccm_wren = grant & wr; dccm_rden = grant & !wr. Never both high.
  - Both address outputs carry the granted address.
  - dccm_wr_data_lo carries the granted wdata.
  - With no grant, address/data outputs are 0.
- **Read return.**
  - Registered rd_pend_lsu, rd_pend_dma and rd_tag_q are captured from the read grant.
  - Next cycle: lsu_rd_valid = rd_pend_lsu; dma_rd_valid = rd_pend_dma; dma_rd_tag = rd_tag_q.
  - Both lsu_rd_data and dma_rd_data = dccm_rd_data_lo when their valid is high, else 0.
- **Writes.** No response; the write completes in the grant cycle.
- **Reset.**
  - Buffer, counter and pending flags clear.
  - All outputs 0 during reset, including dma_req_ready.
  - A read granted in the cycle before reset produces no response.

## Timing
- LSU request valid in cycle N with no DMA buffered: rden/wren in N; read data (lsu_rd_valid) in N+1.
- DMA accepted at edge ending cycle N: buf_valid in N+1.
  - Earliest grant is N+1; dma_rd_valid in N+2.
  - Sustained throughput is 1 request/cycle when LSU is idle.
- LSU continuously valid with DMA buffered:
  - DMA blocked for DMA_STARVE_MAX cycles.
  - dma_starve and DMA grant in the next cycle; LSU stalled that cycle.
  - Counter then clears.
- Simultaneous DMA grant and new DMA accept: the buffer reloads, and the counter clears then restarts counting.
- No combinational path from dccm_rd_data_lo to any grant or ready signal.

## Test plan
- **Reset.** Assert rst 3 cycles with lsu_req_valid=1 and dma_req_valid=1 → all outputs 0. First cycle after reset: dma_req_ready=1 and no DCCM enable.
- **LSU read.** lsu read addr 0x0040, LSU idle otherwise → dccm_rden=1 with rd addr 0x0040 in same cycle. Next cycle lsu_rd_valid=1, lsu_rd_data = model word; dma_rd_valid=0.
- **DMA back-to-back.** 4 DMA reads, tags 0..3, LSU idle → dma_req_ready stays 1. dma_rd_valid in 4 consecutive cycles with tags 0,1,2,3 in order.
- **Starvation.** LSU valid every cycle, one DMA write buffered, DMA_STARVE_MAX=7 → LSU granted 7 cycles. In the 8th cycle dma_starve=1, dccm_wren carries the DMA addr/data, and lsu_req_ready=0.
- **Interleave.** LSU read and DMA read alternate → exactly one of dccm_rden/dccm_wren per cycle. Each response goes to the correct owner with the correct tag; no lost or duplicated responses over 200 random cycles.
- **Reset mid-read.** DMA read granted in cycle N, rst asserted in N+1 → dma_rd_valid=0 in N+1, and the buffer is empty after reset.

Source files
------------

// File: rtl/el2_dccm_port_arb.sv
// -----------------------------------------------------------------------------
// el2_dccm_port_arb
//
// Shares the single DCCM read/write port between the LSU and the DMA slave.
// The LSU is unbuffered and has default priority. The DMA has a one-entry
// request buffer. A saturating counter lets a blocked DMA entry take the port
// after DMA_STARVE_MAX cycles. The arbiter drives the DCCM low-lane
// control/data and routes the 1-cycle-latency read data back to whichever
// requester issued the read.
//
// Ports
//   clk, rst            : core clock, synchronous active-high reset
//   lsu_req_*           : LSU request (valid/wr/addr/wdata) and ready (grant)
//   dma_req_*           : DMA request (valid/wr/addr/wdata/tag) and ready
//                         (buffer can accept)
//   dccm_*              : DCCM port drive and returning read data
//   lsu_rd_*            : LSU read response
//   dma_rd_*            : DMA read response with tag
//   dma_starve          : starvation override active this cycle
// -----------------------------------------------------------------------------
module el2_dccm_port_arb #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39,
   parameter int DMA_STARVE_MAX   = 7,
   parameter int DMA_TAG_W        = 3
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        lsu_req_valid,
   input  logic                        lsu_req_wr,
   input  logic [DCCM_BITS-1:0]        lsu_req_addr,
   input  logic [DCCM_FDATA_WIDTH-1:0] lsu_req_wdata,
   output logic                        lsu_req_ready,

   input  logic                        dma_req_valid,
   input  logic                        dma_req_wr,
   input  logic [DCCM_BITS-1:0]        dma_req_addr,
   input  logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata,
   input  logic [DMA_TAG_W-1:0]        dma_req_tag,
   output logic                        dma_req_ready,

   output logic                        dccm_wren,
   output logic                        dccm_rden,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
   output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
   input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,

   output logic                        lsu_rd_valid,
   output logic [DCCM_FDATA_WIDTH-1:0] lsu_rd_data,
   output logic                        dma_rd_valid,
   output logic [DMA_TAG_W-1:0]        dma_rd_tag,
   output logic [DCCM_FDATA_WIDTH-1:0] dma_rd_data,
   output logic                        dma_starve
);

   localparam int CNT_W = $clog2(DMA_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DMA_STARVE_MAX);

   // DMA request buffer
   logic                        buf_valid_q, buf_valid_d;
   logic                        buf_wr_q,    buf_wr_d;
   logic [DCCM_BITS-1:0]        buf_addr_q,  buf_addr_d;
   logic [DCCM_FDATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;
   logic [DMA_TAG_W-1:0]        buf_tag_q,   buf_tag_d;

   // Starvation counter and read-return tracking
   logic [CNT_W-1:0]            starve_cnt_q, starve_cnt_d;
   logic                        rd_pend_lsu_q, rd_pend_lsu_d;
   logic                        rd_pend_dma_q, rd_pend_dma_d;
   logic [DMA_TAG_W-1:0]        rd_tag_q, rd_tag_d;

   logic starve_active;
   logic dma_grant;
   logic lsu_grant;
   logic dma_accept;

   // Every grant/ready term is qualified with !rst so that all outputs read 0
   // while reset is held, even though the flops only clear at the edge.
   // None of these depend on dccm_rd_data_lo.
   assign starve_active = !rst && buf_valid_q && (starve_cnt_q == STARVE_MAX);
   assign dma_grant     = !rst && buf_valid_q && (!lsu_req_valid || starve_active);
   assign lsu_grant     = !rst && lsu_req_valid && !dma_grant;
   assign dma_accept    = dma_req_valid && dma_req_ready;

   assign dma_starve    = starve_active;
   assign lsu_req_ready = lsu_grant;
   assign dma_req_ready = !rst && (!buf_valid_q || dma_grant);

   // Port drive: mux of the granted request, zeros when idle.
   always_comb begin
      dccm_wren       = 1'b0;
      dccm_rden       = 1'b0;
      dccm_wr_addr_lo = '0;
      dccm_rd_addr_lo = '0;
      dccm_wr_data_lo = '0;
      if (dma_grant) begin
         dccm_wren       = buf_wr_q;
         dccm_rden       = !buf_wr_q;
         dccm_wr_addr_lo = buf_addr_q;
         dccm_rd_addr_lo = buf_addr_q;
         dccm_wr_data_lo = buf_wdata_q;
      end else if (lsu_grant) begin
         dccm_wren       = lsu_req_wr;
         dccm_rden       = !lsu_req_wr;
         dccm_wr_addr_lo = lsu_req_addr;
         dccm_rd_addr_lo = lsu_req_addr;
         dccm_wr_data_lo = lsu_req_wdata;
      end
   end

   // Next-state logic
   always_comb begin
      buf_valid_d  = buf_valid_q;
      buf_wr_d     = buf_wr_q;
      buf_addr_d   = buf_addr_q;
      buf_wdata_d  = buf_wdata_q;
      buf_tag_d    = buf_tag_q;
      starve_cnt_d = starve_cnt_q;

      // A reload in the grant cycle wins over the clear, giving 1 req/cycle.
      if (dma_accept) begin
         buf_valid_d = 1'b1;
         buf_wr_d    = dma_req_wr;
         buf_addr_d  = dma_req_addr;
         buf_wdata_d = dma_req_wdata;
         buf_tag_d   = dma_req_tag;
      end else if (dma_grant) begin
         buf_valid_d = 1'b0;
      end

      // The counter measures how long the current buffered entry has waited,
      // so a grant restarts it even if a new entry is loaded the same cycle.
      if (dma_grant || !buf_valid_q) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      rd_pend_lsu_d = lsu_grant && !lsu_req_wr;
      rd_pend_dma_d = dma_grant && !buf_wr_q;
      rd_tag_d      = (dma_grant && !buf_wr_q) ? buf_tag_q : rd_tag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q   <= 1'b0;
         buf_wr_q      <= 1'b0;
         buf_addr_q    <= '0;
         buf_wdata_q   <= '0;
         buf_tag_q     <= '0;
         starve_cnt_q  <= '0;
         rd_pend_lsu_q <= 1'b0;
         rd_pend_dma_q <= 1'b0;
         rd_tag_q      <= '0;
      end else begin
         buf_valid_q   <= buf_valid_d;
         buf_wr_q      <= buf_wr_d;
         buf_addr_q    <= buf_addr_d;
         buf_wdata_q   <= buf_wdata_d;
         buf_tag_q     <= buf_tag_d;
         starve_cnt_q  <= starve_cnt_d;
         rd_pend_lsu_q <= rd_pend_lsu_d;
         rd_pend_dma_q <= rd_pend_dma_d;
         rd_tag_q      <= rd_tag_d;
      end
   end

   // Read return. The pending flags are gated by rst so that a read granted
   // just before reset never produces a response.
   assign lsu_rd_valid = !rst && rd_pend_lsu_q;
   assign dma_rd_valid = !rst && rd_pend_dma_q;
   assign dma_rd_tag   = rst ? '0 : rd_tag_q;
   assign lsu_rd_data  = lsu_rd_valid ? dccm_rd_data_lo : '0;
   assign dma_rd_data  = dma_rd_valid ? dccm_rd_data_lo : '0;

endmodule
